// File: rtl/mcpu_mem_tlb_pkg.sv
// Shared definitions for the memory-side TLB: field widths, FSM encodings, entry layout.
package mcpu_mem_tlb_pkg;

  localparam int unsigned VpnW   = 20;
  localparam int unsigned PpnW   = 20;
  localparam int unsigned FlagsW = 4;

  // FSM encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [VpnW-1:0]   vpn;
    logic [PpnW-1:0]   ppn;
    logic [FlagsW-1:0] pd_flags;
    logic [FlagsW-1:0] pt_flags;
  } tlb_entry_t;

  // A translation is usable only when both directory and table entries are present.
  function automatic logic both_present(input logic [FlagsW-1:0] pd, input logic [FlagsW-1:0] pt);
    return pd[0] & pt[0];
  endfunction

endpackage

// File: rtl/mcpu_mem_tlb_cam.sv
// Fully associative entry store: parallel tag match, hit index encode, single write port, flush.
module mcpu_mem_tlb_cam
  import mcpu_mem_tlb_pkg::*;
#(
  parameter int unsigned Entries = 8,
  localparam int unsigned IdxW   = $clog2(Entries)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [VpnW-1:0]   lookup_vpn_i,
  output logic              hit_o,
  output logic [PpnW-1:0]   hit_ppn_o,
  output logic [FlagsW-1:0] hit_pd_flags_o,
  output logic [FlagsW-1:0] hit_pt_flags_o,
  input  logic              we_i,
  input  logic [IdxW-1:0]   waddr_i,
  input  tlb_entry_t        wentry_i
);

  tlb_entry_t entries_q [Entries];
  logic [Entries-1:0] match;
  logic [IdxW-1:0]    hit_idx;

  // Entry storage; flush takes priority over a same-cycle install.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (we_i) begin
      entries_q[waddr_i] <= wentry_i;
    end
  end

  // Parallel compare; at most one entry can match, so OR-ing indices gives the encoded hit.
  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < Entries; i++) begin
      match[i] = entries_q[i].valid && (entries_q[i].vpn == lookup_vpn_i);
      if (match[i]) begin
        hit_idx = hit_idx | IdxW'(i);
      end
    end
  end

  assign hit_o          = |match;
  assign hit_ppn_o      = entries_q[hit_idx].ppn;
  assign hit_pd_flags_o = entries_q[hit_idx].pd_flags;
  assign hit_pt_flags_o = entries_q[hit_idx].pt_flags;

endmodule

// File: rtl/mcpu_mem_tlb.sv
// Memory-side TLB: answers hits in one cycle, otherwise runs one page-table walk and
// installs the result into a round-robin victim slot.
module mcpu_mem_tlb
  import mcpu_mem_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic         clkrst_mem_clk,
  input  logic         clkrst_mem_rst,
  // client side
  input  logic         tlb_re,
  input  logic [31:12] tlb_addr,
  input  logic [19:0]  tlb_pagedir_base,
  input  logic         tlb_flush,
  output logic         tlb_ready,
  output logic         tlb_rvalid,
  output logic [31:12] tlb_phys_addr,
  output logic [3:0]   tlb_pagedir_flags,
  output logic [3:0]   tlb_pagetab_flags,
  // walker side
  output logic         tlb2ptw_re,
  output logic [31:12] tlb2ptw_addr,
  output logic [19:0]  tlb2ptw_pagedir_base,
  input  logic         tlb2ptw_ready,
  input  logic [31:12] tlb2ptw_phys_addr,
  input  logic [3:0]   tlb2ptw_pagedir_flags,
  input  logic [3:0]   tlb2ptw_pagetab_flags
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [PpnW-1:0]   phys_q, phys_d;
  logic [FlagsW-1:0] pdf_q, pdf_d;
  logic [FlagsW-1:0] ptf_q, ptf_d;
  logic [VpnW-1:0]   addr_q, addr_d;
  logic [19:0]       base_q, base_d;
  logic              no_install_q, no_install_d;
  logic [IdxW-1:0]   victim_q;

  logic              cam_hit;
  logic [PpnW-1:0]   cam_ppn;
  logic [FlagsW-1:0] cam_pdf;
  logic [FlagsW-1:0] cam_ptf;
  logic              lookup_hit;
  logic              install;
  logic              ptw_re;
  tlb_entry_t        new_entry;

  // A same-cycle flush means the lookup must see an empty table.
  assign lookup_hit = cam_hit & ~tlb_flush;

  assign new_entry = '{valid: 1'b1, vpn: addr_q, ppn: phys_q, pd_flags: pdf_q, pt_flags: ptf_q};

  mcpu_mem_tlb_cam #(
    .Entries (ENTRIES)
  ) u_cam (
    .clk_i          (clkrst_mem_clk),
    .rst_i          (clkrst_mem_rst),
    .flush_i        (tlb_flush),
    .lookup_vpn_i   (tlb_addr),
    .hit_o          (cam_hit),
    .hit_ppn_o      (cam_ppn),
    .hit_pd_flags_o (cam_pdf),
    .hit_pt_flags_o (cam_ptf),
    .we_i           (install),
    .waddr_i        (victim_q),
    .wentry_i       (new_entry)
  );

  // Request FSM: lookup in IDLE, walk on miss, single-cycle response.
  always_comb begin
    state_d      = state_q;
    rvalid_d     = 1'b0;
    phys_d       = phys_q;
    pdf_d        = pdf_q;
    ptf_d        = ptf_q;
    addr_d       = addr_q;
    base_d       = base_q;
    no_install_d = no_install_q;
    install      = 1'b0;
    ptw_re       = 1'b0;
    case (state_q)
      StIdle: begin
        no_install_d = 1'b0;
        if (tlb_re && ready_q) begin
          addr_d = tlb_addr;
          base_d = tlb_pagedir_base;
          if (lookup_hit) begin
            rvalid_d = 1'b1;
            phys_d   = cam_ppn;
            pdf_d    = cam_pdf;
            ptf_d    = cam_ptf;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (tlb_flush) no_install_d = 1'b1;
        if (tlb2ptw_ready) begin
          ptw_re  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (tlb_flush) no_install_d = 1'b1;
        if (tlb2ptw_ready) begin
          rvalid_d = 1'b1;
          phys_d   = both_present(tlb2ptw_pagedir_flags, tlb2ptw_pagetab_flags) ?
                     tlb2ptw_phys_addr : '0;
          pdf_d    = tlb2ptw_pagedir_flags;
          ptf_d    = tlb2ptw_pagetab_flags;
          state_d  = StResp;
        end
      end
      StResp: begin
        install = both_present(pdf_q, ptf_q) & ~no_install_q & ~tlb_flush;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so ready stays low through reset and rises one cycle after release.
    ready_d = (state_d == StIdle);
  end

  // FSM and datapath registers.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      phys_q       <= '0;
      pdf_q        <= '0;
      ptf_q        <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      no_install_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rvalid_q     <= rvalid_d;
      phys_q       <= phys_d;
      pdf_q        <= pdf_d;
      ptf_q        <= ptf_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      no_install_q <= no_install_d;
    end
  end

  // Round-robin replacement pointer; restarts at slot 0 whenever the table is flushed.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      victim_q <= '0;
    end else if (tlb_flush) begin
      victim_q <= '0;
    end else if (install) begin
      victim_q <= victim_q + IdxW'(1);
    end
  end

  assign tlb_ready            = ready_q;
  assign tlb_rvalid           = rvalid_q;
  assign tlb_phys_addr        = phys_q;
  assign tlb_pagedir_flags    = pdf_q;
  assign tlb_pagetab_flags    = ptf_q;
  assign tlb2ptw_re           = ptw_re;
  assign tlb2ptw_addr         = addr_q;
  assign tlb2ptw_pagedir_base = base_q;

endmodule

// File: tb/tb_mcpu_mem_tlb.sv
// Directed bench for mcpu_mem_tlb with a fixed-latency walker stub.
module tb_mcpu_mem_tlb;

  localparam int Lat     = 3;            // cycles the stub holds ready low after a walk
  localparam int MissLat = 1 + Lat + 2;  // ISSUE, ready-low window, ready-high WAIT, RESP

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tlb_re = 1'b0;
  logic [19:0] tlb_addr = '0;
  logic [19:0] tlb_base = 20'h0CAFE;
  logic        tlb_flush = 1'b0;
  logic        tlb_ready, tlb_rvalid;
  logic [19:0] tlb_phys;
  logic [3:0]  tlb_pdf, tlb_ptf;
  logic        ptw_re;
  logic [19:0] ptw_addr, ptw_base;
  logic        ptw_ready;
  logic [19:0] ptw_ppn;
  logic [3:0]  ptw_pdf, ptw_ptf;

  logic [3:0]  stub_pdf = 4'h1;
  logic [3:0]  stub_ptf = 4'h1;
  int          stub_cnt;
  int          walks;
  int          rv_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mcpu_mem_tlb #(
    .ENTRIES (8)
  ) dut (
    .clkrst_mem_clk        (clk),
    .clkrst_mem_rst        (rst),
    .tlb_re                (tlb_re),
    .tlb_addr              (tlb_addr),
    .tlb_pagedir_base      (tlb_base),
    .tlb_flush             (tlb_flush),
    .tlb_ready             (tlb_ready),
    .tlb_rvalid            (tlb_rvalid),
    .tlb_phys_addr         (tlb_phys),
    .tlb_pagedir_flags     (tlb_pdf),
    .tlb_pagetab_flags     (tlb_ptf),
    .tlb2ptw_re            (ptw_re),
    .tlb2ptw_addr          (ptw_addr),
    .tlb2ptw_pagedir_base  (ptw_base),
    .tlb2ptw_ready         (ptw_ready),
    .tlb2ptw_phys_addr     (ptw_ppn),
    .tlb2ptw_pagedir_flags (ptw_pdf),
    .tlb2ptw_pagetab_flags (ptw_ptf)
  );

  function automatic logic [19:0] model_ppn(input logic [19:0] vpn);
    return (vpn == 20'h12345) ? 20'hABCDE : vpn + 20'h00100;
  endfunction

  // Walker stub: accepts on ready&re, drops ready for Lat cycles, then presents the result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptw_ready <= 1'b1;
      stub_cnt  <= 0;
      walks     <= 0;
      ptw_ppn   <= '0;
      ptw_pdf   <= '0;
      ptw_ptf   <= '0;
    end else if (ptw_ready) begin
      if (ptw_re) begin
        ptw_ready <= 1'b0;
        stub_cnt  <= Lat;
        walks     <= walks + 1;
        ptw_ppn   <= model_ppn(ptw_addr);
        ptw_pdf   <= stub_pdf;
        ptw_ptf   <= stub_ptf;
      end
    end else if (stub_cnt == 1) begin
      ptw_ready <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (tlb_rvalid) rv_count <= rv_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tlb_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tlb_ready) check({tag, "_ready_timeout"}, 32'(tlb_ready), 32'd1);
  endtask

  // One translation; optionally pulses flush once the walker has dropped ready (FSM in WAIT).
  task automatic do_req(input string tag, input logic [19:0] vpn, input bit exp_miss,
                        input logic [19:0] exp_ppn, input logic [3:0] exp_pdf,
                        input logic [3:0] exp_ptf, input bit flush_wait);
    int lat = 0;
    int w0;
    bit got = 0;
    bit flushed = 0;
    wait_ready(tag);
    w0       = walks;
    tlb_addr = vpn;
    tlb_re   = 1'b1;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      tlb_re    = 1'b0;
      tlb_flush = 1'b0;
      if (tlb_rvalid) got = 1;
      else if (flush_wait && !flushed && !ptw_ready) begin
        tlb_flush = 1'b1;
        flushed   = 1;
      end
    end
    tlb_flush = 1'b0;
    check({tag, "_rvalid"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"}, 32'(lat), exp_miss ? 32'(MissLat) : 32'd1);
      check({tag, "_walks"}, 32'(walks - w0), exp_miss ? 32'd1 : 32'd0);
      check({tag, "_ppn"}, 32'(tlb_phys), 32'(exp_ppn));
      check({tag, "_pdf"}, 32'(tlb_pdf), 32'(exp_pdf));
      check({tag, "_ptf"}, 32'(tlb_ptf), 32'(exp_ptf));
    end
  endtask

  initial begin
    int w0;
    int rv0;
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(tlb_ready), 32'd0);
    check("rst_rvalid", 32'(tlb_rvalid), 32'd0);
    check("rst_ptw_re", 32'(ptw_re), 32'd0);
    check("rst_phys", 32'(tlb_phys), 32'd0);
    rst = 1'b0;
    #1 check("rel_ready0", 32'(tlb_ready), 32'd0);
    @(negedge clk);
    check("rel_ready1", 32'(tlb_ready), 32'd1);

    // First miss then a hit on the same page
    do_req("miss1", 20'h12345, 1, 20'hABCDE, 4'h1, 4'h1, 0);
    do_req("hit1", 20'h12345, 0, 20'hABCDE, 4'h1, 4'h1, 0);

    // Directory entry not present: zero ppn, flags passed through, never installed
    stub_pdf = 4'h0;
    do_req("np1", 20'h00777, 1, 20'h0, 4'h0, 4'h1, 0);
    do_req("np2", 20'h00777, 1, 20'h0, 4'h0, 4'h1, 0);
    stub_pdf = 4'h1;

    // Flush in IDLE, then overfill the table by one
    wait_ready("flush");
    tlb_flush = 1'b1;
    @(negedge clk);
    tlb_flush = 1'b0;
    for (int v = 0; v < 9; v++) do_req("fill", 20'(v), 1, 20'(v + 256), 4'h1, 4'h1, 0);
    for (int v = 1; v < 9; v++) do_req("fillhit", 20'(v), 0, 20'(v + 256), 4'h1, 4'h1, 0);
    do_req("evict0", 20'd0, 1, 20'h100, 4'h1, 4'h1, 0);
    // vpn 0 went to slot 1, so the pointer had wrapped to 1 and vpn 1 is gone
    do_req("evict1", 20'd1, 1, 20'h101, 4'h1, 4'h1, 0);
    do_req("keep3", 20'd3, 0, 20'h103, 4'h1, 4'h1, 0);

    // Back-to-back hits on slots 4..7
    wait_ready("b2b");
    w0       = walks;
    tlb_re   = 1'b1;
    tlb_addr = 20'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_rvalid", 32'(tlb_rvalid), 32'd1);
      check("b2b_ppn", 32'(tlb_phys), 32'(20'd4 + 20'(i) + 20'h100));
      if (i < 3) tlb_addr = 20'd5 + 20'(i);
      else tlb_re = 1'b0;
    end
    check("b2b_walks", 32'(walks - w0), 32'd0);

    // Flush while waiting on the walker: response still delivered, nothing kept
    do_req("fw", 20'h00500, 1, 20'h00600, 4'h1, 4'h1, 1);
    do_req("fw_again", 20'h00500, 1, 20'h00600, 4'h1, 4'h1, 0);
    do_req("fw_old", 20'd4, 1, 20'h104, 4'h1, 4'h1, 0);

    // Reset while the walk is outstanding
    wait_ready("rstw");
    tlb_addr = 20'h00700;
    tlb_re   = 1'b1;
    @(negedge clk);
    tlb_re = 1'b0;
    n = 0;
    while (ptw_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstw_in_wait", 32'(ptw_ready), 32'd0);
    rst = 1'b1;
    rv0 = rv_count;
    repeat (2) @(negedge clk);
    check("rstw_ready_in_rst", 32'(tlb_ready), 32'd0);
    rst = 1'b0;
    #1 check("rstw_ready_rel", 32'(tlb_ready), 32'd0);
    @(negedge clk);
    check("rstw_ready_up", 32'(tlb_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("rstw_no_rvalid", 32'(rv_count - rv0), 32'd0);
    do_req("rstw_miss500", 20'h00500, 1, 20'h00600, 4'h1, 4'h1, 0);
    do_req("rstw_miss4", 20'd4, 1, 20'h104, 4'h1, 4'h1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
